// File: rtl/registro_estavel.sv
// Stability capture register: samples In while enabled and flags when the
// value held steady for STABLE samples, or when TIMEOUT edges passed first.
module registro_estavel #(
    parameter int WIDTH   = 4,
    parameter int STABLE  = 2,
    parameter int TIMEOUT = 15
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] In,
    input  logic             Hab,
    output logic [WIDTH-1:0] Saida,
    output logic             Fim,
    output logic             Erro
);

    localparam int EW = (STABLE > 0) ? $clog2(STABLE + 1) : 1;
    localparam int TW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    localparam logic [EW-1:0] EST_LAST = EW'(STABLE - 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE,
        CAPT,
        DONE,
        FAIL
    } state_t;

    state_t          r_state;
    logic [EW-1:0]   r_cnt_est;
    logic [TW-1:0]   r_cnt_tmo;

    logic            w_match;
    logic            w_done;
    logic            w_tmo;

    assign w_match = (In == Saida);
    assign w_done  = w_match && (r_cnt_est == EST_LAST);
    assign w_tmo   = (TIMEOUT != 0) && (r_cnt_tmo == TMO_LAST);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= IDLE;
            Saida     <= '0;
            Fim       <= 1'b0;
            Erro      <= 1'b0;
            r_cnt_est <= '0;
            r_cnt_tmo <= '0;
        end else if (!Hab) begin
            r_state   <= IDLE;
            Fim       <= 1'b0;
            Erro      <= 1'b0;
            r_cnt_est <= '0;
            r_cnt_tmo <= '0;
        end else begin
            unique case (r_state)
                IDLE: begin
                    Saida     <= In;
                    r_cnt_est <= '0;
                    r_cnt_tmo <= '0;
                    r_state   <= CAPT;
                end
                CAPT: begin
                    Saida <= In;
                    if (TIMEOUT != 0)
                        r_cnt_tmo <= r_cnt_tmo + TW'(1);
                    r_cnt_est <= w_match ? r_cnt_est + EW'(1) : '0;
                    // Completion has priority over an expiring timeout
                    if (w_done) begin
                        Fim     <= 1'b1;
                        r_state <= DONE;
                    end else if (w_tmo) begin
                        Erro    <= 1'b1;
                        r_state <= FAIL;
                    end
                end
                DONE: r_state <= DONE;
                FAIL: r_state <= FAIL;
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_registro_estavel.sv
// Bench for registro_estavel: three parameter sets checked every cycle
// against a run-length session model plus directed literal expectations.
module tb_registro_estavel;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic [3:0]  in0, in1;
    logic [15:0] in2;
    logic        hab0, hab1, hab2;
    logic [3:0]  s0, s1;
    logic [15:0] s2;
    logic        f0, f1, f2, e0, e1, e2;

    registro_estavel u0 (
        .clk(clk), .rst(rst), .In(in0), .Hab(hab0),
        .Saida(s0), .Fim(f0), .Erro(e0)
    );

    registro_estavel #(.WIDTH(4), .STABLE(2), .TIMEOUT(4)) u1 (
        .clk(clk), .rst(rst), .In(in1), .Hab(hab1),
        .Saida(s1), .Fim(f1), .Erro(e1)
    );

    registro_estavel #(.WIDTH(16), .STABLE(1), .TIMEOUT(1)) u2 (
        .clk(clk), .rst(rst), .In(in2), .Hab(hab2),
        .Saida(s2), .Fim(f2), .Erro(e2)
    );

    int n_vec = 0;
    int n_err = 0;

    // Session model: samples taken so far and trailing run of equal samples
    int          m_n   [3];
    int          m_run [3];
    logic [15:0] m_sai [3];

    function automatic int st(int k);
        return (k == 2) ? 1 : 2;
    endfunction

    function automatic int tmo(int k);
        return (k == 0) ? 15 : ((k == 1) ? 4 : 1);
    endfunction

    function automatic logic [15:0] din(int k);
        return (k == 0) ? 16'(in0) : ((k == 1) ? 16'(in1) : in2);
    endfunction

    function automatic logic hab_of(int k);
        return (k == 0) ? hab0 : ((k == 1) ? hab1 : hab2);
    endfunction

    function automatic logic [15:0] o_sai(int k);
        return (k == 0) ? 16'(s0) : ((k == 1) ? 16'(s1) : s2);
    endfunction

    function automatic logic o_fim(int k);
        return (k == 0) ? f0 : ((k == 1) ? f1 : f2);
    endfunction

    function automatic logic o_err(int k);
        return (k == 0) ? e0 : ((k == 1) ? e1 : e2);
    endfunction

    function automatic logic m_done(int k);
        return m_run[k] >= st(k) + 1;
    endfunction

    function automatic logic m_fail(int k);
        return !m_done(k) && tmo(k) != 0 && m_n[k] >= tmo(k) + 1;
    endfunction

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int k = 0; k < 3; k++) begin
                m_n[k]   <= 0;
                m_run[k] <= 0;
                m_sai[k] <= 16'h0;
            end
        end else begin
            for (int k = 0; k < 3; k++) begin
                if (!hab_of(k)) begin
                    m_n[k]   <= 0;
                    m_run[k] <= 0;
                end else if (!m_done(k) && !m_fail(k)) begin
                    m_n[k]   <= m_n[k] + 1;
                    m_run[k] <= (m_n[k] > 0 && din(k) == m_sai[k])
                                ? m_run[k] + 1 : 1;
                    m_sai[k] <= din(k);
                end
            end
        end
    end

    task automatic chk(string nm, logic [15:0] act, logic [15:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic cmp_model();
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("model_saida%0d", k), o_sai(k), m_sai[k]);
            chk($sformatf("model_fim%0d", k), 16'(o_fim(k)), 16'(m_done(k)));
            chk($sformatf("model_erro%0d", k), 16'(o_err(k)), 16'(m_fail(k)));
            chk($sformatf("excl%0d", k), 16'(o_fim(k) & o_err(k)), 16'h0);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cmp_model();
    endtask

    initial begin
        rst  = 1'b1;
        hab0 = 1'b0; hab1 = 1'b0; hab2 = 1'b0;
        in0  = 4'h0; in1 = 4'h0; in2 = 16'h0;
        #1 rst = 1'b0;
        #2;
        chk("rst_saida0", 16'(s0), 16'h0);
        chk("rst_fim0", 16'(f0), 16'h0);
        chk("rst_erro0", 16'(e0), 16'h0);
        cmp_model();
        @(negedge clk);
        rst  = 1'b1;
        hab0 = 1'b1; in0 = 4'hA;
        hab1 = 1'b1; in1 = 4'h1;
        hab2 = 1'b1; in2 = 16'hBEEF;

        for (int i = 1; i <= 5; i++) begin
            in1 = (i % 2 == 1) ? 4'h1 : 4'h2;
            tick();
            if (i == 1) begin
                chk("const_saida_e1", 16'(s0), 16'hA);
                chk("const_fim_e1", 16'(f0), 16'h0);
                chk("w16_saida_e1", s2, 16'hBEEF);
            end
            if (i == 2) begin
                chk("const_fim_e2", 16'(f0), 16'h0);
                chk("w16_fim_e2", 16'(f2), 16'h1);
                chk("w16_erro_e2", 16'(e2), 16'h0);
            end
            if (i == 3) begin
                chk("const_fim_e3", 16'(f0), 16'h1);
                chk("const_erro_e3", 16'(e0), 16'h0);
            end
            if (i == 4)
                chk("tmo_erro_e4", 16'(e1), 16'h0);
            if (i == 5) begin
                chk("tmo_erro_e5", 16'(e1), 16'h1);
                chk("tmo_saida_e5", 16'(s1), 16'h1);
                chk("tmo_fim_e5", 16'(f1), 16'h0);
            end
        end

        in1 = 4'h2;
        tick();
        chk("fail_frozen_a", 16'(s1), 16'h1);
        chk("fail_erro_held", 16'(e1), 16'h1);
        in1 = 4'h3;
        tick();
        chk("fail_frozen_b", 16'(s1), 16'h1);
        hab1 = 1'b0;
        tick();
        chk("fail_exit_erro", 16'(e1), 16'h0);
        chk("fail_exit_saida", 16'(s1), 16'h1);

        in0 = 4'hF;
        tick();
        chk("done_saida_frozen", 16'(s0), 16'hA);
        chk("done_fim_held", 16'(f0), 16'h1);
        hab0 = 1'b0;
        tick();
        chk("done_exit_fim", 16'(f0), 16'h0);
        chk("done_exit_saida", 16'(s0), 16'hA);
        hab0 = 1'b1;
        tick();
        chk("recap_saida", 16'(s0), 16'hF);
        chk("recap_fim_e1", 16'(f0), 16'h0);
        tick();
        tick();
        chk("recap_fim_e3", 16'(f0), 16'h1);

        hab0 = 1'b0;
        tick();
        hab0 = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            in0 = (i <= 2) ? 4'h3 : 4'h5;
            tick();
            if (i == 4)
                chk("mis_fim_e4", 16'(f0), 16'h0);
            if (i == 5) begin
                chk("mis_fim_e5", 16'(f0), 16'h1);
                chk("mis_saida_e5", 16'(s0), 16'h5);
            end
        end

        hab0 = 1'b0;
        tick();
        hab0 = 1'b1;
        in0  = 4'h7;
        tick();
        chk("capt_saida7", 16'(s0), 16'h7);
        #3 rst = 1'b0;
        #1;
        chk("async_saida0", 16'(s0), 16'h0);
        chk("async_fim0", 16'(f0), 16'h0);
        chk("async_erro0", 16'(e0), 16'h0);
        chk("async_saida2", s2, 16'h0);
        cmp_model();
        @(negedge clk);
        rst = 1'b1;
        in0 = 4'h4;
        tick();
        chk("post_rst_saida", 16'(s0), 16'h4);
        chk("post_rst_fim", 16'(f0), 16'h0);
        tick();
        tick();
        chk("post_rst_fim_e3", 16'(f0), 16'h1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/registro_estavel.md
REGISTRO_ESTAVEL -- requirements
Module: registro_estavel

Interface
REQ-001 Parameter WIDTH, default 4: data width in bits; legal range >= 1.
REQ-002 Parameter STABLE, default 2: consecutive matching samples required for completion; legal range >= 1.
REQ-003 Parameter TIMEOUT, default 15: maximum capture edges before failure; 0 disables timeout; when nonzero, TIMEOUT >= STABLE.
REQ-004 clk  input  1  sole clock; all state changes on rising edge.
REQ-005 rst  input  1  reset, asynchronous, active-low.
REQ-006 In  input  WIDTH  data to be captured.
REQ-007 Hab  input  1  enable; high requests a capture session, low aborts or ends it.
REQ-008 Saida  output  WIDTH  registered copy of the last sampled In.
REQ-009 Fim  output  1  registered; high = In held stable for STABLE consecutive samples.
REQ-010 Erro  output  1  registered; high = TIMEOUT expired before stability was reached.

Function
REQ-011 Internal FSM states SHALL be IDLE, CAPT, DONE and FAIL.
REQ-012 Internal counters: match count cnt_est (0..STABLE) and edge count cnt_tmo (0..TIMEOUT), each sized to its range.
REQ-013 Hab=0 at any edge, from any state: next state IDLE; Fim<=0; Erro<=0; Saida holds; counters cleared.
REQ-014 IDLE, Hab=1: Saida<=In; cnt_est<=0; cnt_tmo<=0; next state CAPT; Fim and Erro stay 0.
REQ-015 CAPT, Hab=1, every edge: Saida<=In; cnt_tmo<=cnt_tmo+1.
REQ-016 CAPT match rule: if In==Saida (pre-edge value), cnt_est<=cnt_est+1; otherwise cnt_est<=0.
REQ-017 CAPT completion: a match with cnt_est==STABLE-1 SHALL set Fim<=1 and move to DONE.
REQ-018 CAPT timeout: if TIMEOUT!=0, no completion on this edge, and cnt_tmo==TIMEOUT-1, then Erro<=1 and move to FAIL.
REQ-019 Completion and timeout on the same edge: completion wins; Fim=1, Erro=0.
REQ-020 DONE, Hab=1: Saida frozen; Fim held at 1; In ignored.
REQ-021 FAIL, Hab=1: Saida frozen at last sample; Erro held at 1; In ignored.
REQ-022 Fim and Erro SHALL never both be 1.
REQ-023 Leaving DONE or FAIL requires Hab low for at least one edge, which returns the FSM to IDLE; a new session starts on the next Hab=1 edge.
REQ-024 Latency, constant In with Hab rising before edge 1: Saida valid after edge 1; Fim=1 after edge STABLE+1.
REQ-025 TIMEOUT=0: CAPT persists indefinitely until stability or Hab=0.
REQ-026 Comparison covers all WIDTH bits; no arithmetic is performed on data.

Reset
REQ-027 rst=0 SHALL immediately, without a clock: force state IDLE; Saida=0; Fim=0; Erro=0; clear both counters.
REQ-028 Reset asserted mid-session (CAPT, DONE or FAIL) SHALL discard the session.
REQ-029 After rst rises, operation resumes at the first rising clk edge, behaving as IDLE.

Verification
REQ-030 Defaults; Hab=1, In=0xA constant -> Saida=0xA after edge 1; Fim=1 after edge 3; Erro=0 throughout.
REQ-031 Defaults; In=0x3,0x3,0x5,0x5,0x5 on successive edges -> mismatch at edge 3 resets cnt_est; Fim=1 after edge 5; Saida=0x5.
REQ-032 TIMEOUT=4, STABLE=2; In toggles 0x1/0x2 every edge -> Erro=1 after edge 5; Saida frozen at last sample; Fim=0.
REQ-033 DONE reached; change In to 0xF with Hab=1 -> Saida and Fim unchanged; drop Hab one edge -> Fim=0; Hab=1 again -> new capture of 0xF, Fim=1 two edges later.
REQ-034 Assert rst between edges while in CAPT with Saida=0x7 -> Saida=0, Fim=0, Erro=0 immediately; after release with Hab=1, state is IDLE and the next edge captures In.
REQ-035 WIDTH=16, STABLE=1, TIMEOUT=1; In=0xBEEF constant -> Fim=1 after edge 2, Erro=0, confirming completion wins over timeout.
